control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Multi-cycle control FSM for the simple 16-bit processor.
- Decodes the instruction held in the external IR (a register_n instance) and drives the load strobes of every register_n on the datapath:
  - r_in per general register, plus a_in, g_in and ir_in.
- Drives the matching bus-source selects, so the block is the initiator side of every register_n load.
- Sits between the IR/run/din inputs and the shared 16-bit datapath bus.

Parameters:
- NREG, 8, number of general registers R0..R(NREG-1); fixed at 8 for 3-bit register fields.
- IRW, 9, instruction width; fields are opcode [8:6], X [5:3], Y [2:0].

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  start-of-instruction request, sampled in T0.
- ir  input  IRW  current instruction word (output of the external IR register).
- ir_in  output  1  IR load strobe.
- r_in  output  NREG  one-hot load strobe to R0..R7.
- r_out  output  NREG  one-hot bus-drive select from R0..R7.
- din_out  output  1  bus-drive select for the din input.
- g_out  output  1  bus-drive select for the ALU result register G.
- a_in  output  1  load strobe for ALU operand register A.
- g_in  output  1  load strobe for ALU result register G.
- add_sub  output  1  ALU mode: 0 = add, 1 = subtract.
- done  output  1  one-cycle pulse in the final step of each instruction.

Behaviour:
- FSM states: T0, T1, T2, T3, encoded 2-bit. The state register updates on posedge clk only.
- Reset:
  - rst=1 forces the state to T0 on the next posedge.
  - While rst=1, every output is 0, whatever the state or run.
  - Reset mid-instruction abandons it; no r_in, g_in or done pulse is produced for that instruction.
- Output timing: all outputs are combinational in state, ir and run. Datapath registers capture at the same posedge as the state transition.
- T0:
  - run=0: all outputs 0; stay in T0.
  - run=1: ir_in=1; go to T1. The IR holds the new word from T1 onward.
- Opcodes:
  - 000 mv Rx,Ry: T1 asserts r_out[Y], r_in[X], done; then T0.
  - 001 mvi Rx,#D: T1 asserts din_out, r_in[X], done; then T0.
  - 010 add and 011 sub:
    - T1 asserts r_out[X], a_in; then T2.
    - T2 asserts r_out[Y], g_in, add_sub (0 for add, 1 for sub); then T3.
    - T3 asserts g_out, r_in[X], done; then T0.
  - 100..111 (unused): T1 asserts done only; then T0.
- Latency, counted from the T0 cycle with run=1:
  - mv, mvi and unused opcodes: 2 cycles.
  - add and sub: 4 cycles.
- Back-to-back: if run=1 in the T0 cycle directly after a done, the next instruction starts with no idle cycle.
- run is ignored in T1..T3.
- Bus exclusivity:
  - At most one of r_out, din_out, g_out is nonzero in any cycle.
  - r_in and r_out are each one-hot or zero.
- X==Y cases:
  - mv R3,R3 asserts r_out[3] and r_in[3] together; this is legal.
  - add Rx,Rx doubles Rx.
- add_sub is 0 in every state except T2 of a sub.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - Adds port illegal (output, 1 bit, reset value 0).
  - An unused opcode in T1 sets illegal; it stays set until rst.
  - done is not pulsed and the FSM enters T0 and stays there, ignoring run, until rst.
- Undefined: the illegal port is absent; unused opcodes complete as a 2-cycle no-op with done, as described above.

Decomposition:
- Shared package cpu_pkg holds:
  - the state enum (T0..T3);
  - opcode localparams OP_MV, OP_MVI, OP_ADD, OP_SUB;
  - field-position localparams for opcode, X and Y.
- One sub-module, dec3to8: a combinational 3-to-8 one-hot decoder with an enable input. Two instances are used, one for X and one for Y.

Test Plan:
- Reset: rst=1 for 2 cycles with run=1 and ir=9'o020 -> all outputs 0 and the state is T0. After rst falls, the first run=1 cycle asserts ir_in.
- mv R2,R5 (ir=9'o025): run pulse -> next cycle r_out=8'h20, r_in=8'h04, done=1; the following cycle all outputs are 0.
- mvi R7 (ir=9'o170): T1 asserts din_out=1, r_in=8'h80, done=1, with r_out=0 and g_out=0.
- add R1,R6 (ir=9'o216):
  - T1: r_out=8'h02, a_in=1.
  - T2: r_out=8'h40, g_in=1, add_sub=0.
  - T3: g_out=1, r_in=8'h02, done=1.
  - Repeat as sub (ir=9'o316) -> T2 has add_sub=1.
- Reset mid-add: rst=1 in T2 -> no T3 r_in or done pulse. The FSM is in T0 on the posedge after rst; run is then honoured again.
- Back-to-back and unused opcodes:
  - Program: mv then add, with run held at 1 -> the second ir_in comes in the cycle right after the first done.
  - ir=9'o500 -> done in T1 (macro off). With the macro on -> illegal=1 and sticky, and no further ir_in until rst.
  - Bus-exclusivity assertion is active throughout.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the simple 16-bit processor control path: FSM step
// encoding, opcode values and instruction field positions.
package cpu_pkg;

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } state_t;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;

   localparam int OP_MSB = 8;
   localparam int OP_LSB = 6;
   localparam int X_MSB  = 5;
   localparam int X_LSB  = 3;
   localparam int Y_MSB  = 2;
   localparam int Y_LSB  = 0;

endpackage

// File: rtl/dec3to8.sv
// Combinational 3-to-8 one-hot decoder; all outputs low when en is low.
module dec3to8 (
   input  logic [2:0] sel,
   input  logic       en,
   output logic [7:0] y
);

   always_comb begin
      y = '0;
      if (en) y[sel] = 1'b1;
   end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle T0..T3 control FSM: decodes the external IR and drives every
// register load strobe and bus-source select. Optional trap: CTRL_ILLEGAL_TRAP_EN.
module control_sequencer
   import cpu_pkg::*;
#(
   parameter int NREG = 8,
   parameter int IRW  = 9
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run,
   input  logic [IRW-1:0]  ir,
   output logic            ir_in,
   output logic [NREG-1:0] r_in,
   output logic [NREG-1:0] r_out,
   output logic            din_out,
   output logic            g_out,
   output logic            a_in,
   output logic            g_in,
   output logic            add_sub,
   output logic            done
`ifdef CTRL_ILLEGAL_TRAP_EN
   ,
   output logic            illegal
`endif
);

   state_t state, state_nxt;

   logic [2:0]      opcode;
   logic [2:0]      x_sel;
   logic [2:0]      y_sel;
   logic [NREG-1:0] x_hot;
   logic [NREG-1:0] y_hot;
   logic            rin_x;
   logic            rout_x;
   logic            rout_y;

   assign opcode = ir[OP_MSB:OP_LSB];
   assign x_sel  = ir[X_MSB:X_LSB];
   assign y_sel  = ir[Y_MSB:Y_LSB];

   dec3to8 u_dec_x (
      .sel (x_sel),
      .en  (~rst),
      .y   (x_hot)
   );

   dec3to8 u_dec_y (
      .sel (y_sel),
      .en  (~rst),
      .y   (y_hot)
   );

`ifdef CTRL_ILLEGAL_TRAP_EN
   logic illegal_q;
   logic trap_set;

   // Sticky trap flag; only reset clears it.
   always_ff @(posedge clk) begin
      if (rst)           illegal_q <= 1'b0;
      else if (trap_set) illegal_q <= 1'b1;
   end

   assign illegal = illegal_q & ~rst;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= T0;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ir_in     = 1'b0;
      din_out   = 1'b0;
      g_out     = 1'b0;
      a_in      = 1'b0;
      g_in      = 1'b0;
      add_sub   = 1'b0;
      done      = 1'b0;
      rin_x     = 1'b0;
      rout_x    = 1'b0;
      rout_y    = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      trap_set  = 1'b0;
`endif
      if (!rst) begin
         unique case (state)
            T0: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
               if (run && !illegal_q) begin
`else
               if (run) begin
`endif
                  ir_in     = 1'b1;
                  state_nxt = T1;
               end
            end
            T1: begin
               state_nxt = T0;
               unique case (opcode)
                  OP_MV: begin
                     rout_y = 1'b1;
                     rin_x  = 1'b1;
                     done   = 1'b1;
                  end
                  OP_MVI: begin
                     din_out = 1'b1;
                     rin_x   = 1'b1;
                     done    = 1'b1;
                  end
                  OP_ADD, OP_SUB: begin
                     rout_x    = 1'b1;
                     a_in      = 1'b1;
                     state_nxt = T2;
                  end
                  default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                     trap_set = 1'b1;
`else
                     done     = 1'b1;
`endif
                  end
               endcase
            end
            T2: begin
               rout_y    = 1'b1;
               g_in      = 1'b1;
               add_sub   = (opcode == OP_SUB);
               state_nxt = T3;
            end
            T3: begin
               g_out     = 1'b1;
               rin_x     = 1'b1;
               done      = 1'b1;
               state_nxt = T0;
            end
            default: state_nxt = T0;
         endcase
      end
   end

   // X drives the bus only in T1 of add/sub, so X and Y selects never overlap.
   assign r_in  = rin_x  ? x_hot : '0;
   assign r_out = rout_x ? x_hot : (rout_y ? y_hot : '0);

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized self-checking bench for control_sequencer against a step-table
// model of each instruction class.
module tb_control_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       run;
   logic [8:0] ir;
   logic       ir_in;
   logic [7:0] r_in;
   logic [7:0] r_out;
   logic       din_out;
   logic       g_out;
   logic       a_in;
   logic       g_in;
   logic       add_sub;
   logic       done;
`ifdef CTRL_ILLEGAL_TRAP_EN
   logic       illegal;
`endif

   int checks = 0;
   int errors = 0;

   logic [22:0] obs;
   assign obs = {ir_in, r_in, r_out, din_out, g_out, a_in, g_in, add_sub, done};

   control_sequencer #(.NREG(8), .IRW(9)) dut (
      .clk     (clk),
      .rst     (rst),
      .run     (run),
      .ir      (ir),
      .ir_in   (ir_in),
      .r_in    (r_in),
      .r_out   (r_out),
      .din_out (din_out),
      .g_out   (g_out),
      .a_in    (a_in),
      .g_in    (g_in),
      .add_sub (add_sub),
      .done    (done)
`ifdef CTRL_ILLEGAL_TRAP_EN
      ,
      .illegal (illegal)
`endif
   );

   always #5 clk = ~clk;

   // Expected outputs for cycle 'step' of an instruction (step 0 is the T0 run cycle).
   function automatic logic [22:0] exp_out(input logic [8:0] w, input int step);
      logic       e_ir_in, e_din, e_gout, e_ain, e_gin, e_as, e_done;
      logic [7:0] e_rin, e_rout;
      int op, x, y;
      op = int'(w[8:6]);
      x  = int'(w[5:3]);
      y  = int'(w[2:0]);
      {e_ir_in, e_din, e_gout, e_ain, e_gin, e_as, e_done} = '0;
      e_rin  = '0;
      e_rout = '0;
      if (step == 0) begin
         e_ir_in = 1'b1;
      end else begin
         case (op)
            0: if (step == 1) begin e_rout = 8'd1 << y; e_rin = 8'd1 << x; e_done = 1'b1; end
            1: if (step == 1) begin e_din = 1'b1; e_rin = 8'd1 << x; e_done = 1'b1; end
            2, 3: begin
               if (step == 1) begin e_rout = 8'd1 << x; e_ain = 1'b1; end
               if (step == 2) begin e_rout = 8'd1 << y; e_gin = 1'b1; e_as = (op == 3); end
               if (step == 3) begin e_gout = 1'b1; e_rin = 8'd1 << x; e_done = 1'b1; end
            end
            default: begin
`ifndef CTRL_ILLEGAL_TRAP_EN
               if (step == 1) e_done = 1'b1;
`endif
            end
         endcase
      end
      return {e_ir_in, e_rin, e_rout, e_din, e_gout, e_ain, e_gin, e_as, e_done};
   endfunction

   function automatic int instr_len(input logic [8:0] w);
      return (w[8:6] == 3'd2 || w[8:6] == 3'd3) ? 4 : 2;
   endfunction

   // Bus-exclusivity and one-hot monitor, active for the whole run.
   always @(negedge clk) begin
      checks++;
      if ((int'(|r_out) + int'(din_out) + int'(g_out)) > 1 ||
          $countones(r_in) > 1 || $countones(r_out) > 1) begin
         errors++;
         $display("FAIL bus_excl r_out=%h din_out=%b g_out=%b r_in=%h required exclusive one-hot",
                  r_out, din_out, g_out, r_in);
      end
   end

   task automatic test_reset();
      rst = 1'b1; run = 1'b1; ir = 9'o020;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== 23'd0) begin
            errors++;
            $display("FAIL reset_outs got %h required %h", obs, 23'd0);
         end
`ifdef CTRL_ILLEGAL_TRAP_EN
         checks++;
         if (illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_illegal got %b required 0", illegal);
         end
`endif
         @(posedge clk); #1;
      end
      rst = 1'b0;
      for (int s = 0; s < instr_len(ir); s++) begin
         @(negedge clk);
         checks++;
         if (obs !== exp_out(ir, s)) begin
            errors++;
            $display("FAIL reset_release step %0d got %h required %h", s, obs, exp_out(ir, s));
         end
         @(posedge clk); #1;
         run = 1'b0;
      end
   endtask

   task automatic test_directed();
      logic [8:0] prog [4];
      prog = '{9'o025, 9'o170, 9'o216, 9'o316};
      foreach (prog[k]) begin
         run = 1'b1; ir = prog[k];
         for (int s = 0; s < instr_len(ir); s++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_out(ir, s)) begin
               errors++;
               $display("FAIL directed ir=%o step %0d got %h required %h", ir, s, obs, exp_out(ir, s));
            end
            @(posedge clk); #1;
            run = 1'b0;
         end
         @(negedge clk);
         checks++;
         if (obs !== 23'd0) begin
            errors++;
            $display("FAIL directed_idle ir=%o got %h required %h", ir, obs, 23'd0);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid_add();
      run = 1'b1; ir = 9'o216;
      for (int s = 0; s < 2; s++) begin
         @(negedge clk);
         checks++;
         if (obs !== exp_out(ir, s)) begin
            errors++;
            $display("FAIL midrst_pre step %0d got %h required %h", s, obs, exp_out(ir, s));
         end
         @(posedge clk); #1;
         run = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== 23'd0) begin
         errors++;
         $display("FAIL midrst_t2 got %h required %h", obs, 23'd0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== 23'd0) begin
         errors++;
         $display("FAIL midrst_no_t3 got %h required %h", obs, 23'd0);
      end
      @(posedge clk); #1;
      run = 1'b1; ir = 9'o025;
      for (int s = 0; s < 2; s++) begin
         @(negedge clk);
         checks++;
         if (obs !== exp_out(ir, s)) begin
            errors++;
            $display("FAIL midrst_resume step %0d got %h required %h", s, obs, exp_out(ir, s));
         end
         @(posedge clk); #1;
         run = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      logic [8:0] prog [5];
      prog = '{9'o025, 9'o216, 9'o170, 9'o314, 9'o033};
      run = 1'b1;
      foreach (prog[k]) begin
         ir = prog[k];
         for (int s = 0; s < instr_len(ir); s++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_out(ir, s)) begin
               errors++;
               $display("FAIL b2b ir=%o step %0d got %h required %h", ir, s, obs, exp_out(ir, s));
            end
            @(posedge clk); #1;
         end
      end
      run = 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== 23'd0) begin
         errors++;
         $display("FAIL b2b_idle got %h required %h", obs, 23'd0);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      logic [8:0] w;
      for (int n = 0; n < 200; n++) begin
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
            run = 1'b0; ir = 9'($urandom);
            @(negedge clk);
            checks++;
            if (obs !== 23'd0) begin
               errors++;
               $display("FAIL rand_idle got %h required %h", obs, 23'd0);
            end
            @(posedge clk); #1;
         end
         w = 9'($urandom);
`ifdef CTRL_ILLEGAL_TRAP_EN
         w[8] = 1'b0;
`endif
         run = 1'b1; ir = w;
         for (int s = 0; s < instr_len(w); s++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_out(w, s)) begin
               errors++;
               $display("FAIL rand ir=%o step %0d got %h required %h", w, s, obs, exp_out(w, s));
            end
            @(posedge clk); #1;
            run = 1'($urandom);
         end
      end
      run = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_unused();
      run = 1'b1; ir = 9'o500;
`ifdef CTRL_ILLEGAL_TRAP_EN
      @(negedge clk);
      checks++;
      if (obs !== exp_out(ir, 0)) begin
         errors++;
         $display("FAIL trap_t0 got %h required %h", obs, exp_out(ir, 0));
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (obs !== 23'd0 || illegal !== 1'b0) begin
         errors++;
         $display("FAIL trap_t1 got %h/%b required %h/0", obs, illegal, 23'd0);
      end
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         ir = 9'o025;
         @(negedge clk);
         checks++;
         if (obs !== 23'd0 || illegal !== 1'b1) begin
            errors++;
            $display("FAIL trap_sticky got %h/%b required %h/1", obs, illegal, 23'd0);
         end
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (illegal !== 1'b0) begin
         errors++;
         $display("FAIL trap_rst_illegal got %b required 0", illegal);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== exp_out(ir, 0) || illegal !== 1'b0) begin
         errors++;
         $display("FAIL trap_recover got %h/%b required %h/0", obs, illegal, exp_out(ir, 0));
      end
      @(posedge clk); #1;
      run = 1'b0;
      @(posedge clk); #1;
`else
      for (int s = 0; s < 2; s++) begin
         @(negedge clk);
         checks++;
         if (obs !== exp_out(ir, s)) begin
            errors++;
            $display("FAIL unused step %0d got %h required %h", s, obs, exp_out(ir, s));
         end
         @(posedge clk); #1;
      end
      run = 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== 23'd0) begin
         errors++;
         $display("FAIL unused_idle got %h required %h", obs, 23'd0);
      end
      @(posedge clk); #1;
`endif
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; ir = '0;
      test_reset();
      test_directed();
      test_reset_mid_add();
      test_back_to_back();
      test_random();
      test_unused();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
